// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Optional rx->tx bypass on an empty FIFO is enabled by defining SYNC_FIFO_BYPASS_EN.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_rx_valid,
  output logic                  fifo_rx_ready,
  input  logic [DATA_WIDTH-1:0] fifo_rx_data,
  output logic                  fifo_tx_valid,
  input  logic                  fifo_tx_ready,
  output logic [DATA_WIDTH-1:0] fifo_tx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic [AW-1:0]         wr_idx_s;
  logic [AW-1:0]         rd_idx_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;

  assign wr_idx_s      = wr_ptr_r[AW-1:0];
  assign rd_idx_s      = rd_ptr_r[AW-1:0];
  assign empty_s       = (wr_ptr_r == rd_ptr_r);
  assign full_s        = (wr_idx_s == rd_idx_s) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign fifo_rx_ready = !full_s;

  // Head presentation and push/pop qualification; a bypassed word is never stored.
  always_comb begin
    fifo_tx_valid = !empty_s;
    fifo_tx_data  = {DATA_WIDTH{1'b0}};
    push_s        = fifo_rx_valid && !full_s;
    pop_s         = !empty_s && fifo_tx_ready;
    if (empty_s) begin
`ifdef SYNC_FIFO_BYPASS_EN
      if (fifo_rx_valid) begin
        fifo_tx_valid = 1'b1;
        fifo_tx_data  = fifo_rx_data;
        push_s        = !fifo_tx_ready;
      end else begin
        fifo_tx_data  = {DATA_WIDTH{1'b0}};
      end
`else
      fifo_tx_data = {DATA_WIDTH{1'b0}};
`endif
    end else begin
      fifo_tx_data = mem_r[rd_idx_s];
    end
  end

  // Pointer update; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_idx_s] <= fifo_rx_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed scoreboard bench for sync_fifo: reset, single word, fill/drain, full-with-pop,
// streaming, mid-operation reset and a short random mix.
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          fifo_rx_valid;
  logic          fifo_rx_ready;
  logic [DW-1:0] fifo_rx_data;
  logic          fifo_tx_valid;
  logic          fifo_tx_ready;
  logic [DW-1:0] fifo_tx_data;

  logic [DW-1:0] exp_q[$];
  int            n_vec;
  int            n_err;
  bit            chk_en;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rx_valid (fifo_rx_valid),
    .fifo_rx_ready (fifo_rx_ready),
    .fifo_rx_data  (fifo_rx_data),
    .fifo_tx_valid (fifo_tx_valid),
    .fifo_tx_ready (fifo_tx_ready),
    .fifo_tx_data  (fifo_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check pre-edge outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    int  sz;
    bit  pop_m;
    bit  push_m;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    fifo_rx_valid = v;
    fifo_rx_data  = d;
    fifo_tx_ready = r;
    #4;
    sz        = exp_q.size();
    exp_valid = (sz > 0);
    exp_data  = (sz > 0) ? exp_q[0] : {DW{1'b0}};
    push_m    = v && (sz < DEPTH);
`ifdef SYNC_FIFO_BYPASS_EN
    if (sz == 0 && v) begin
      exp_valid = 1'b1;
      exp_data  = d;
      if (r) push_m = 1'b0;
    end
`endif
    pop_m = (sz > 0) && r;
    if (chk_en) begin
      check("tx_valid", {31'd0, fifo_tx_valid}, {31'd0, exp_valid});
      check("rx_ready", {31'd0, fifo_rx_ready}, {31'd0, (sz < DEPTH)});
      check("tx_data", fifo_tx_data, exp_data);
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    rst           = 1'b1;
    fifo_rx_valid = 1'b0;
    fifo_rx_data  = '0;
    fifo_tx_ready = 1'b0;

    // Reset held two cycles; outputs are defined only after the first edge.
    cycle(1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);

    // Single word, held under back-pressure, then popped.
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);

    // Fill to full; the ninth word is refused.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0);
    cycle(1'b1, 32'h9, 1'b0);
    cycle(1'b1, 32'h9, 1'b0);
    // Drain in order on consecutive cycles.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);

    // Full with a same-cycle pop still refuses the push.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0);
    cycle(1'b1, 32'h9, 1'b1);
    cycle(1'b1, 32'h30, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1);

    // Continuous streaming with the consumer always ready.
    for (int i = 0; i < 32; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);

    // Mid-operation reset discards five stored words; handshakes in the reset cycle are ignored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0);
    rst = 1'b1;
    cycle(1'b1, 32'h77, 1'b1);
    rst = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hA5, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);

    // Random mix exercises pointer wrap and occupancy changes.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
